hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage MIPS core. It reads the fields the ID/EX register presents to EX, together with the ID-stage source registers and the EX branch/jump resolution. It drives the write-enable, flush and bubble controls that feed PC, IF/ID and ID/EX. It also owns the halt drain sequence and a saturating stall-cycle counter that the debug unit reads.

---
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX hazard inputs, EX resolution, debug requests
// and the pipeline enable/flush/bubble controls returned to the datapath.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_BITS = 16
);
  logic [4:0]          i_id_rs;
  logic [4:0]          i_id_rt;
  logic                i_id_use_rs;
  logic                i_id_use_rt;
  logic                i_id_halt;
  logic [4:0]          i_idex_rt;
  logic                i_idex_mem_op;
  logic                i_idex_mem_type;
  logic                i_ex_branch_taken;
  logic                i_ex_jump;
  logic                i_mem_busy;
  logic                i_resume;
  logic                o_pc_write;
  logic                o_ifid_write;
  logic                o_ifid_flush;
  logic                o_idex_bubble;
  logic                o_halted;
  logic [1:0]          o_state;
  logic [CNT_BITS-1:0] o_stall_cnt;

  modport slave (
    input  i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_halt,
    input  i_idex_rt, i_idex_mem_op, i_idex_mem_type,
    input  i_ex_branch_taken, i_ex_jump, i_mem_busy, i_resume,
    output o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble,
    output o_halted, o_state, o_stall_cnt
  );

  modport master (
    output i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt, i_id_halt,
    output i_idex_rt, i_idex_mem_op, i_idex_mem_type,
    output i_ex_branch_taken, i_ex_jump, i_mem_busy, i_resume,
    input  o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble,
    input  o_halted, o_state, o_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/bubble controller for the 5-stage core: load-use and branch
// hazards, the halt drain sequence and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_BITS     = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_BAD    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          drain_q, drain_d;
  logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

  logic taken_s;
  logic lu_s;
  logic pc_write_s;
  logic ifid_write_s;
  logic flush_s;
  logic bubble_s;

  assign taken_s = bus.i_ex_branch_taken | bus.i_ex_jump;
  assign lu_s    = bus.i_idex_mem_op & bus.i_idex_mem_type & (bus.i_idex_rt != 5'd0) &
                   ((bus.i_id_use_rs & (bus.i_id_rs == bus.i_idex_rt)) |
                    (bus.i_id_use_rt & (bus.i_id_rt == bus.i_idex_rt)));

  // Next-state and Mealy pipeline controls.
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    pc_write_s   = 1'b1;
    ifid_write_s = 1'b1;
    flush_s      = 1'b0;
    bubble_s     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.i_mem_busy) begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
        end else if (taken_s) begin
          flush_s  = 1'b1;
          bubble_s = 1'b1;
        end else if (bus.i_id_halt) begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          bubble_s     = 1'b1;
          drain_d      = 4'd1;
          state_d      = ST_DRAIN;
        end else if (lu_s) begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          bubble_s     = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (bus.i_mem_busy) begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
        end else if (taken_s) begin
          // The halt being drained sat on the wrong path.
          flush_s  = 1'b1;
          bubble_s = 1'b1;
          drain_d  = 4'd0;
          state_d  = ST_RUN;
        end else begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          bubble_s     = 1'b1;
          if (drain_q == 4'(DRAIN_CYCLES)) begin
            drain_d = 4'd0;
            state_d = ST_HALTED;
          end else begin
            drain_d = drain_q + 4'd1;
          end
        end
      end
      ST_HALTED: begin
        bubble_s = 1'b1;
        if (bus.i_resume) begin
          flush_s = 1'b1;
          state_d = ST_RUN;
        end else begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
        end
      end
      default: begin
        drain_d = 4'd0;
        state_d = ST_RUN;
      end
    endcase
  end

  // Stall cycles outside HALTED, saturating at all-ones.
  always_comb begin
    if (!pc_write_s && (state_q != ST_HALTED) && (stall_cnt_q != {CNT_BITS{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State, drain counter and stall counter registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_RUN;
      drain_q     <= 4'd0;
      stall_cnt_q <= {CNT_BITS{1'b0}};
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Controls are held inactive for the whole reset interval.
  assign bus.o_pc_write    = i_rst & pc_write_s;
  assign bus.o_ifid_write  = i_rst & ifid_write_s;
  assign bus.o_ifid_flush  = i_rst & flush_s;
  assign bus.o_idex_bubble = i_rst & bubble_s;
  assign bus.o_halted      = (state_q == ST_HALTED);
  assign bus.o_state       = state_q;
  assign bus.o_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a behavioural model pushes expected
// outputs per cycle; they are popped and compared on the falling edge.
module tb_hazard_ctrl;

  localparam int unsigned DRAIN    = 3;
  localparam int unsigned CNT_BITS = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_BITS(CNT_BITS)) bus ();

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_BITS(CNT_BITS)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       halt;
    logic [4:0] idex_rt;
    logic       mem_op;
    logic       mem_type;
    logic       br;
    logic       jmp;
    logic       busy;
    logic       resume;
  } stim_t;

  typedef struct packed {
    logic [3:0]          ctrl;
    logic [1:0]          state;
    logic                halted;
    logic [CNT_BITS-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]          m_state;
  int                  m_drain;
  logic [CNT_BITS-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t load_use(input logic [4:0] r);
    stim_t s;
    s = '0;
    s.idex_rt  = r;
    s.mem_op   = 1'b1;
    s.mem_type = 1'b1;
    s.rs       = r;
    s.use_rs   = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.i_id_rs           = s.rs;
    bus.i_id_rt           = s.rt;
    bus.i_id_use_rs       = s.use_rs;
    bus.i_id_use_rt       = s.use_rt;
    bus.i_id_halt         = s.halt;
    bus.i_idex_rt         = s.idex_rt;
    bus.i_idex_mem_op     = s.mem_op;
    bus.i_idex_mem_type   = s.mem_type;
    bus.i_ex_branch_taken = s.br;
    bus.i_ex_jump         = s.jmp;
    bus.i_mem_busy        = s.busy;
    bus.i_resume          = s.resume;
  endtask

  task automatic model_reset();
    m_state = 2'd0;
    m_drain = 0;
    m_cnt   = '0;
  endtask

  // One clock: drive, predict, compare at negedge, advance model at posedge.
  task automatic step(input stim_t s, input string tag);
    exp_t       e;
    logic       pcw, ifw, fl, bub, taken, lu;
    logic [1:0] ns;
    int         nd;
    apply(s);
    taken = s.br | s.jmp;
    lu    = s.mem_op & s.mem_type & (s.idex_rt != 5'd0) &
            ((s.use_rs & (s.rs == s.idex_rt)) | (s.use_rt & (s.rt == s.idex_rt)));
    pcw = 1'b1; ifw = 1'b1; fl = 1'b0; bub = 1'b0;
    ns  = m_state; nd = m_drain;
    if (m_state == 2'd0) begin
      if (s.busy) begin pcw = 1'b0; ifw = 1'b0; end
      else if (taken) begin fl = 1'b1; bub = 1'b1; end
      else if (s.halt) begin pcw = 1'b0; ifw = 1'b0; bub = 1'b1; nd = 1; ns = 2'd1; end
      else if (lu) begin pcw = 1'b0; ifw = 1'b0; bub = 1'b1; end
    end else if (m_state == 2'd1) begin
      if (s.busy) begin pcw = 1'b0; ifw = 1'b0; end
      else if (taken) begin fl = 1'b1; bub = 1'b1; nd = 0; ns = 2'd0; end
      else begin
        pcw = 1'b0; ifw = 1'b0; bub = 1'b1;
        if (m_drain == int'(DRAIN)) begin ns = 2'd2; nd = 0; end
        else nd = m_drain + 1;
      end
    end else begin
      bub = 1'b1;
      if (s.resume) begin fl = 1'b1; ns = 2'd0; end
      else begin pcw = 1'b0; ifw = 1'b0; end
    end
    e.ctrl   = {pcw, ifw, fl, bub};
    e.state  = m_state;
    e.halted = (m_state == 2'd2);
    e.cnt    = m_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check({tag, "_ctrl"}, {28'd0, bus.o_pc_write, bus.o_ifid_write, bus.o_ifid_flush, bus.o_idex_bubble},
          {28'd0, e.ctrl});
    check({tag, "_state"}, {30'd0, bus.o_state}, {30'd0, e.state});
    check({tag, "_halted"}, {31'd0, bus.o_halted}, {31'd0, e.halted});
    check({tag, "_cnt"}, 32'(bus.o_stall_cnt), 32'(e.cnt));
    @(posedge clk);
    if (!pcw && (m_state != 2'd2) && (m_cnt != {CNT_BITS{1'b1}})) m_cnt = m_cnt + 1'b1;
    m_state = ns;
    m_drain = nd;
    #1;
  endtask

  initial begin
    stim_t s;
    apply(idle());
    model_reset();
    #12;
    check("rst_ctrl", {28'd0, bus.o_pc_write, bus.o_ifid_write, bus.o_ifid_flush, bus.o_idex_bubble}, 32'd0);
    check("rst_state", {30'd0, bus.o_state}, 32'd0);
    check("rst_halted", {31'd0, bus.o_halted}, 32'd0);
    check("rst_cnt", 32'(bus.o_stall_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(idle(), "rel");

    // Load-use on r5 stalls one cycle; r0 never does.
    step(load_use(5'd5), "lu5");
    step(idle(), "lu5_after");
    check("lu5_cnt", 32'(bus.o_stall_cnt), 32'd1);
    step(load_use(5'd0), "lu0");
    check("lu0_cnt", 32'(bus.o_stall_cnt), 32'd1);

    s = load_use(5'd5); s.br = 1'b1;
    step(s, "br_lu");
    check("br_lu_cnt", 32'(bus.o_stall_cnt), 32'd1);

    // Halt drain, halted, resume.
    s = idle(); s.halt = 1'b1;
    step(s, "halt");
    check("halt_state", {30'd0, bus.o_state}, 32'd1);
    for (int i = 0; i < 3; i++) step(idle(), "drain");
    check("halted_state", {30'd0, bus.o_state}, 32'd2);
    check("halted_flag", {31'd0, bus.o_halted}, 32'd1);
    check("halted_cnt", 32'(bus.o_stall_cnt), 32'd5);
    step(idle(), "halted_idle");
    s = idle(); s.resume = 1'b1;
    step(s, "resume");
    check("resume_state", {30'd0, bus.o_state}, 32'd0);

    // Jump during drain aborts the halt.
    s = idle(); s.halt = 1'b1;
    step(s, "halt2");
    s = idle(); s.jmp = 1'b1;
    step(s, "abort");
    check("abort_state", {30'd0, bus.o_state}, 32'd0);
    check("abort_halted", {31'd0, bus.o_halted}, 32'd0);
    check("abort_cnt", 32'(bus.o_stall_cnt), 32'd6);

    // Memory busy freezes over a pending load-use.
    s = load_use(5'd5); s.busy = 1'b1;
    for (int i = 0; i < 4; i++) step(s, "busy");
    step(load_use(5'd5), "busy_lu");
    step(idle(), "busy_after");
    check("busy_cnt", 32'(bus.o_stall_cnt), 32'd11);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      s = idle();
      s.rs       = 5'($urandom_range(0, 7));
      s.rt       = 5'($urandom_range(0, 7));
      s.use_rs   = 1'($urandom_range(0, 1));
      s.use_rt   = 1'($urandom_range(0, 1));
      s.idex_rt  = 5'($urandom_range(0, 7));
      s.mem_op   = 1'($urandom_range(0, 1));
      s.mem_type = 1'($urandom_range(0, 1));
      s.halt     = ($urandom_range(0, 9) == 0);
      s.br       = ($urandom_range(0, 7) == 0);
      s.jmp      = ($urandom_range(0, 7) == 0);
      s.busy     = ($urandom_range(0, 7) == 0);
      s.resume   = ($urandom_range(0, 3) == 0);
      step(s, "rnd");
    end
    for (int i = 0; i < 4; i++) step(idle(), "settle");
    s = idle(); s.resume = 1'b1;
    step(s, "settle_res");

    // Asynchronous reset in the middle of a drain.
    s = idle(); s.halt = 1'b1;
    step(s, "halt3");
    step(idle(), "drain3");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_ctrl", {28'd0, bus.o_pc_write, bus.o_ifid_write, bus.o_ifid_flush, bus.o_idex_bubble}, 32'd0);
    check("arst_state", {30'd0, bus.o_state}, 32'd0);
    check("arst_halted", {31'd0, bus.o_halted}, 32'd0);
    check("arst_cnt", 32'(bus.o_stall_cnt), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    step(idle(), "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
